// File: rtl/alu_muldiv_seq.sv
// Small ALU with single-cycle logic/arith ops plus sequential shift-add MULTU
// and restoring DIVU writing the HI/LO pair.
module alu_muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;

  localparam logic [3:0] OP_MULTU = 4'b1000;
  localparam logic [3:0] OP_DIVU  = 4'b1001;
  localparam int         CW       = $clog2(WIDTH + 1);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic             pend;
  logic [3:0]       op_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] single_res;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_ok;

  assign busy = (state != IDLE);

  always_comb begin
    single_res = '0;
    case (op_r)
      4'b0000: single_res = a_r & b_r;
      4'b0001: single_res = a_r | b_r;
      4'b0010: single_res = a_r + b_r;
      4'b0110: single_res = a_r - b_r;
      4'b0111: single_res = {{(WIDTH-1){1'b0}}, ($signed(a_r) < $signed(b_r))};
      4'b1100: single_res = ~(a_r | b_r);
      4'b1010: single_res = hi;
      4'b1011: single_res = lo;
      default: single_res = '0;
    endcase
  end

  // Multiply: {acc, a_r} is the product/multiplier shift register, b_r the multiplicand.
  // Divide: acc is the partial remainder, a_r shifts dividend out and quotient in.
  always_comb begin
    mul_sum   = {1'b0, acc} + (a_r[0] ? {1'b0, b_r} : '0);
    div_shift = {acc, a_r[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_r};
    div_ok    = (div_shift >= {1'b0, b_r});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      pend     <= 1'b0;
      op_r     <= '0;
      a_r      <= '0;
      b_r      <= '0;
      acc      <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      result   <= '0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      pend     <= 1'b0;
      if (pend) begin
        result <= single_res;
        done   <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (start) begin
            op_r <= op;
            a_r  <= a;
            b_r  <= b;
            acc  <= '0;
            if (op == OP_MULTU) begin
              state <= MUL;
              cnt   <= CW'(WIDTH);
            end else if (op == OP_DIVU) begin
              state <= DIV;
              cnt   <= CW'(WIDTH);
            end else begin
              pend <= 1'b1;
            end
          end
        end
        MUL: begin
          if (cnt != '0) begin
            acc <= mul_sum[WIDTH:1];
            a_r <= {mul_sum[0], a_r[WIDTH-1:1]};
            cnt <= cnt - 1'b1;
          end else begin
            hi     <= acc;
            lo     <= a_r;
            result <= a_r;
            done   <= 1'b1;
            state  <= IDLE;
          end
        end
        DIV: begin
          if (cnt != '0) begin
            acc <= div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            a_r <= {a_r[WIDTH-2:0], div_ok};
            cnt <= cnt - 1'b1;
          end else begin
            hi       <= acc;
            lo       <= a_r;
            result   <= a_r;
            div_zero <= (b_r == '0);
            done     <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_muldiv_seq.md
ALU_MULDIV_SEQ -- requirements
Module: alu_muldiv_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits; legal range 8..64.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  operation request; sampled only when busy=0.
REQ-005 SHALL have port op  input  4  operation select, captured on acceptance.
REQ-006 SHALL have ports a, b  input  WIDTH each  operands, captured on acceptance.
REQ-007 SHALL have port busy  output  1  high while a multi-cycle operation is in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse: result valid.
REQ-009 SHALL have port result  output  WIDTH  registered result, held until next done.
REQ-010 SHALL have port div_zero  output  1  valid with done; high if the completed op was DIVU with b=0.
REQ-011 SHALL have ports hi, lo  output  WIDTH each  architectural HI/LO registers.

Function
REQ-012 SHALL decode op: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed), 1100 NOR, 1000 MULTU, 1001 DIVU, 1010 MFHI, 1011 MFLO; any other code yields result 0.
REQ-013 SHALL accept a request on a rising edge where start=1 and busy=0 (state IDLE); start while busy=1 ignored, no queuing.
REQ-014 SHALL, for single-cycle ops (all except MULTU/DIVU), update result and pulse done on the edge following acceptance; busy stays 0; back-to-back requests every cycle are legal.
REQ-015 SHALL implement ADD/SUB modulo 2^WIDTH, carry/overflow discarded; SLT result 1 if signed a<signed b else 0.
REQ-016 SHALL, for MULTU, enter state MUL, perform shift-add over exactly WIDTH cycles (busy=1), then go to IDLE with done=1 one edge later; total latency WIDTH+1 edges from acceptance.
REQ-017 SHALL, on MULTU completion, write {hi,lo} = unsigned 2*WIDTH-bit product of a*b and set result = low WIDTH bits, same edge as done.
REQ-018 SHALL, for DIVU, enter state DIV, perform restoring division over exactly WIDTH cycles, latency WIDTH+1 as for MULTU.
REQ-019 SHALL, on DIVU completion, write lo = quotient, hi = remainder, result = quotient.
REQ-020 SHALL, for DIVU with b=0, run full latency and produce quotient all-ones, remainder = a, div_zero=1 with done.
REQ-021 SHALL keep hi/lo unchanged by all ops except MULTU/DIVU completion and reset.
REQ-022 SHALL, for MFHI/MFLO, return hi/lo value current at acceptance (single-cycle).
REQ-023 SHALL hold div_zero=0 for every completion other than DIVU with b=0.
REQ-024 SHALL use operand copies captured at acceptance; changes on a/b/op during busy have no effect.
REQ-025 SHALL implement state machine IDLE -> MUL|DIV -> IDLE only; no other states.

Reset
REQ-026 SHALL, when rst=1 at an edge, force state IDLE, busy=0, done=0, div_zero=0, result=0, hi=0, lo=0, iteration counter=0.
REQ-027 SHALL abort an in-progress MULTU/DIVU on reset with no done pulse and no HI/LO update.
REQ-028 SHALL give rst priority over start in the same cycle; request is dropped.

Verification (WIDTH=32)
REQ-029 SHALL test single-cycle ops: ADD a=0xFFFFFFFF,b=1 -> result 0, done next edge; SLT a=0xFFFFFFFF,b=1 -> 1; NOR a=0,b=0 -> 0xFFFFFFFF.
REQ-030 SHALL test MULTU a=0xFFFFFFFF,b=0xFFFFFFFF -> done at edge 33, hi=0xFFFFFFFE, lo=0x00000001, result=0x00000001; then MFHI -> 0xFFFFFFFE.
REQ-031 SHALL test DIVU a=100,b=7 -> done at edge 33, lo=14, hi=2, div_zero=0.
REQ-032 SHALL test DIVU a=0x1234,b=0 -> result=0xFFFFFFFF, hi=0x1234, div_zero=1.
REQ-033 SHALL test start pulses during busy with differing op/a/b -> ignored; completed MULTU result unchanged, exactly one done.
REQ-034 SHALL test rst asserted at cycle 10 of a MULTU -> busy=0 next edge, no done, hi=lo=0; new ADD accepted immediately after.
